// File: rtl/dout_seq_gen.sv
// Multi-lane serial pattern generator with divided sclk, end-of-frame sync and repeat/abort.
// Define DOUT_SEQ_GEN_MSB_FIRST_EN to shift each lane from bit seq_length-1 down to bit 0.
module dout_seq_gen #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 1024,
    parameter int LEN_W  = 10,
    parameter int REP_W  = 8,
    parameter int DIV    = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] data_reg,
    input  logic [LEN_W-1:0]       seq_length,
    input  logic [REP_W-1:0]       rep_count,
    input  logic                   trig,
    input  logic                   abort,
    input  logic                   clr_mode,
    input  logic                   clr_2_one,
    output logic                   sclk,
    output logic [N_CH-1:0]        dout,
    output logic                   syn,
    output logic                   out_en,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PH_W  = $clog2(2 * DIV);
`ifdef DOUT_SEQ_GEN_MSB_FIRST_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SYNC
    } state_e;

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   pos_q;
    logic [LEN_W-1:0]   pos_d;
    logic [LEN_W-1:0]   first_len;
    logic [REP_W-1:0]   rep_q;
    logic [REP_W-1:0]   rep_max_q;
    logic [PH_W-1:0]    phase_q;
    logic               trig_q;
    logic               sclk_q;
    logic               syn_q;
    logic               out_en_q;
    logic               busy_q;
    logic               done_q;
    logic [N_CH-1:0]    dout_q;
    logic [N_CH-1:0]    bits_d;
    logic [N_CH-1:0]    idle_lvl;
    logic [DATA_W-1:0]  lane [N_CH];
    logic               trig_edge;
    logic               len_ok;
    logic               bit_end;
    logic               last_bit;
    logic               more_reps;

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        assign lane[k] = data_reg[k*DATA_W +: DATA_W];
    end

    // Position of the next bit to drive: first bit of a frame, or the next one within it.
    always_comb begin
        first_len = (state_q == IDLE) ? seq_length : len_q;
        pos_d     = '0;
        bits_d    = '0;
        if (state_q == SHIFT) begin
            pos_d = DESC ? pos_q - LEN_W'(1) : pos_q + LEN_W'(1);
        end else begin
            pos_d = DESC ? first_len - LEN_W'(1) : '0;
        end
        for (int k = 0; k < N_CH; k++) begin
            bits_d[k] = lane[k][IDX_W'(pos_d)];
        end
    end

    assign trig_edge = trig & ~trig_q;
    assign len_ok    = (seq_length != '0) &&
                       ({1'b0, seq_length} <= (LEN_W+1)'(DATA_W));
    assign bit_end   = (phase_q == PH_W'(2*DIV-1));
    assign last_bit  = (cnt_q == len_q - LEN_W'(1));
    assign more_reps = (rep_q < rep_max_q);
    assign idle_lvl  = clr_mode ? {N_CH{clr_2_one}} : '0;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            pos_q     <= '0;
            rep_q     <= '0;
            rep_max_q <= '0;
            phase_q   <= '0;
            trig_q    <= 1'b0;
            sclk_q    <= 1'b0;
            dout_q    <= '0;
            syn_q     <= 1'b0;
            out_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            trig_q <= trig;
            done_q <= 1'b0;
            if (state_q != IDLE && abort) begin
                state_q  <= IDLE;
                sclk_q   <= 1'b0;
                dout_q   <= idle_lvl;
                syn_q    <= 1'b0;
                out_en_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        dout_q <= idle_lvl;
                        if (trig_edge && len_ok) begin
                            state_q   <= SHIFT;
                            len_q     <= seq_length;
                            rep_max_q <= rep_count;
                            rep_q     <= '0;
                            cnt_q     <= '0;
                            pos_q     <= pos_d;
                            phase_q   <= '0;
                            sclk_q    <= 1'b0;
                            dout_q    <= bits_d;
                            out_en_q  <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (bit_end) begin
                            phase_q <= '0;
                            sclk_q  <= 1'b0;
                            if (last_bit) begin
                                state_q  <= SYNC;
                                dout_q   <= '0;
                                syn_q    <= 1'b1;
                                out_en_q <= 1'b0;
                            end else begin
                                cnt_q  <= cnt_q + LEN_W'(1);
                                pos_q  <= pos_d;
                                dout_q <= bits_d;
                            end
                        end else begin
                            phase_q <= phase_q + PH_W'(1);
                            sclk_q  <= (phase_q >= PH_W'(DIV-1));
                        end
                    end
                    SYNC: begin
                        if (bit_end) begin
                            phase_q <= '0;
                            syn_q   <= 1'b0;
                            if (more_reps) begin
                                state_q  <= SHIFT;
                                rep_q    <= rep_q + REP_W'(1);
                                cnt_q    <= '0;
                                pos_q    <= pos_d;
                                dout_q   <= bits_d;
                                out_en_q <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                                dout_q  <= idle_lvl;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            phase_q <= phase_q + PH_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sclk   = sclk_q;
    assign dout   = dout_q;
    assign syn    = syn_q;
    assign out_en = out_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_dout_seq_gen.sv
// Randomized self-checking bench for dout_seq_gen against a per-cycle frame model.
// The model builds the full expected output stream from the frame/repeat rules.
module tb_dout_seq_gen;

    localparam int N_CH   = 2;
    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;
    localparam int REP_W  = 8;
    localparam int DIV    = 2;
    localparam int BP     = 2 * DIV;

    logic                   clk_in = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N_CH*DATA_W-1:0] data_reg = '0;
    logic [LEN_W-1:0]       seq_length = '0;
    logic [REP_W-1:0]       rep_count = '0;
    logic                   trig = 1'b0;
    logic                   abort = 1'b0;
    logic                   clr_mode = 1'b0;
    logic                   clr_2_one = 1'b0;
    logic                   sclk;
    logic [N_CH-1:0]        dout;
    logic                   syn;
    logic                   out_en;
    logic                   busy;
    logic                   done;
    logic [6:0]             obs;

    int n_tests = 0;
    int n_fail  = 0;
    logic [6:0] exp_q[$];

    dout_seq_gen #(
        .N_CH(N_CH), .DATA_W(DATA_W), .LEN_W(LEN_W), .REP_W(REP_W), .DIV(DIV)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .data_reg(data_reg),
        .seq_length(seq_length), .rep_count(rep_count), .trig(trig),
        .abort(abort), .clr_mode(clr_mode), .clr_2_one(clr_2_one),
        .sclk(sclk), .dout(dout), .syn(syn), .out_en(out_en),
        .busy(busy), .done(done)
    );

    assign obs = {sclk, dout, syn, out_en, busy, done};

    always #5 clk_in = ~clk_in;

    // Expected stream, one entry per clk_in cycle starting the cycle after the edge.
    task automatic build(input logic [15:0] l0, input logic [15:0] l1,
                         input int len, input int rep);
        logic [1:0] idl;
        logic [1:0] b;
        int p;
        idl = clr_mode ? {2{clr_2_one}} : 2'b00;
        exp_q.delete();
        for (int r = 0; r <= rep; r++) begin
            for (int i = 0; i < len; i++) begin
`ifdef DOUT_SEQ_GEN_MSB_FIRST_EN
                p = len - 1 - i;
`else
                p = i;
`endif
                b = {l1[p[3:0]], l0[p[3:0]]};
                for (int c = 0; c < BP; c++)
                    exp_q.push_back({(c >= DIV), b, 4'b0110});
            end
            for (int c = 0; c < BP; c++)
                exp_q.push_back({1'b0, 2'b00, 4'b1010});
        end
        exp_q.push_back({1'b0, idl, 4'b0001});
    endtask

    task automatic arm(input logic [15:0] l0, input logic [15:0] l1,
                       input int len, input int rep);
        data_reg   = {l1, l0};
        seq_length = LEN_W'(len);
        rep_count  = REP_W'(rep);
        trig       = 1'b1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_async got %b exp %b", obs, 7'd0);
        end
        clr_mode  = 1'b1;
        clr_2_one = 1'b1;
        tick(2);
        n_tests++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_held got %b exp %b", obs, 7'd0);
        end
        clr_mode  = 1'b0;
        clr_2_one = 1'b0;
        rst_n     = 1'b1;
        tick(2);
    endtask

    task automatic test_clear_idle();
        logic [1:0] tab_m;
        logic [1:0] tab_o;
        logic [1:0] tab_e [3];
        tab_m = 2'b011;
        tab_o = 2'b001;
        tab_e[0] = 2'b11;
        tab_e[1] = 2'b00;
        tab_e[2] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            clr_mode  = (i < 2);
            clr_2_one = (i == 0);
            tick(2);
            n_tests++;
            if ({dout, syn, busy} !== {tab_e[i], 2'b00}) begin
                n_fail++;
                $display("FAIL clear_idle%0d got %b exp %b",
                         i, {dout, syn, busy}, {tab_e[i], 2'b00});
            end
        end
        if (tab_m == tab_o) clr_mode = 1'b0;
        clr_mode  = 1'b0;
        clr_2_one = 1'b0;
    endtask

    task automatic test_basic(input int rep);
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] e1;
        logic prev;
        int nb;
        int busy_cyc;
        int syn_rise;
        int done_cnt;
        logic prev_syn;
        s0 = '0; s1 = '0; nb = 0; prev = 1'b0;
        busy_cyc = 0; syn_rise = 0; done_cnt = 0; prev_syn = 1'b0;
        arm(16'hA5C3, 16'h0F0F, 8, rep);
        build(16'hA5C3, 16'h0F0F, 8, rep);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk_in); #1; trig = 1'b0;
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_r%0d c%0d got %b exp %b", rep, i, obs, exp_q[i]);
            end
            if (sclk && !prev && nb < 8) begin
                s0[nb] = dout[0];
                s1[nb] = dout[1];
                nb++;
            end
            prev = sclk;
            if (busy) busy_cyc++;
            if (syn && !prev_syn) syn_rise++;
            prev_syn = syn;
            if (done) done_cnt++;
        end
`ifdef DOUT_SEQ_GEN_MSB_FIRST_EN
        e1 = 8'b11110000;
`else
        e1 = 8'b00001111;
`endif
        n_tests++;
        if (rep == 0 && (s0 !== 8'b11000011 || s1 !== e1)) begin
            n_fail++;
            $display("FAIL basic_bits got %b/%b exp %b/%b", s0, s1, 8'b11000011, e1);
        end
        n_tests++;
        if (busy_cyc != 36 * (rep + 1) || syn_rise != rep + 1 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL basic_counts busy %0d syn %0d done %0d exp %0d %0d 1",
                     busy_cyc, syn_rise, done_cnt, 36 * (rep + 1), rep + 1);
        end
        tick(1);
    endtask

    task automatic test_retrigger();
        logic [15:0] l0;
        logic [15:0] l1;
        l0 = 16'($urandom);
        l1 = 16'($urandom);
        arm(l0, l1, 6, 1);
        build(l0, l1, 6, 1);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk_in); #1; trig = 1'b0;
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL retrig c%0d got %b exp %b", i, obs, exp_q[i]);
            end
            if (i == 5 || i == exp_q.size() - 3) begin
                trig       = 1'b1;
                seq_length = 5'd3;
                rep_count  = 8'd4;
            end
        end
        tick(1);
    endtask

    task automatic test_bad_len();
        for (int j = 0; j < 2; j++) begin
            seq_length = (j == 0) ? 5'd0 : 5'd17;
            trig = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk_in); #1; trig = 1'b0;
                n_tests++;
                if ({out_en, busy, done} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL bad_len%0d c%0d got %b exp 000",
                             seq_length, i, {out_en, busy, done});
                end
            end
        end
    endtask

    task automatic test_abort();
        arm(16'hA5C3, 16'h0F0F, 8, 0);
        build(16'hA5C3, 16'h0F0F, 8, 0);
        for (int i = 0; i < 3 * BP + 2; i++) begin
            @(posedge clk_in); #1; trig = 1'b0;
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_pre c%0d got %b exp %b", i, obs, exp_q[i]);
            end
        end
        abort = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in); #1;
            n_tests++;
            if (obs !== 7'd0) begin
                n_fail++;
                $display("FAIL abort_idle c%0d got %b exp %b", i, obs, 7'd0);
            end
        end
        abort = 1'b0;
        arm(16'hA5C3, 16'h0F0F, 8, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk_in); #1; trig = 1'b0;
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL abort_restart c%0d got %b exp %b", i, obs, exp_q[i]);
            end
        end
        tick(1);
    endtask

    task automatic test_reset_mid();
        arm(16'hA5C3, 16'h0F0F, 8, 0);
        build(16'hA5C3, 16'h0F0F, 8, 0);
        for (int i = 0; i < 5 * BP + 1; i++) begin
            @(posedge clk_in); #1; trig = 1'b0;
        end
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre busy got %b exp 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== 7'd0) begin
            n_fail++;
            $display("FAIL rstmid_async got %b exp %b", obs, 7'd0);
        end
        tick(2);
        rst_n = 1'b1;
        tick(1);
        arm(16'hA5C3, 16'h0F0F, 8, 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk_in); #1; trig = 1'b0;
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rstmid_frame c%0d got %b exp %b", i, obs, exp_q[i]);
            end
        end
        tick(1);
    endtask

    task automatic test_random(input int runs);
        logic [15:0] l0;
        logic [15:0] l1;
        int len;
        int rep;
        for (int r = 0; r < runs; r++) begin
            l0  = 16'($urandom);
            l1  = 16'($urandom);
            len = (r == 0) ? 16 : int'($urandom_range(1, 16));
            rep = int'($urandom_range(0, 3));
            clr_mode  = 1'($urandom);
            clr_2_one = 1'($urandom);
            tick(1);
            arm(l0, l1, len, rep);
            build(l0, l1, len, rep);
            for (int i = 0; i < exp_q.size(); i++) begin
                @(posedge clk_in); #1; trig = 1'b0;
                n_tests++;
                if (obs !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d len%0d rep%0d c%0d got %b exp %b",
                             r, len, rep, i, obs, exp_q[i]);
                end
            end
        end
        clr_mode  = 1'b0;
        clr_2_one = 1'b0;
        tick(1);
    endtask

    task automatic test_max_rep();
        int done_cnt;
        int syn_rise;
        logic prev_syn;
        done_cnt = 0; syn_rise = 0; prev_syn = 1'b0;
        arm(16'h0001, 16'h0000, 1, 255);
        build(16'h0001, 16'h0000, 1, 255);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk_in); #1; trig = 1'b0;
            n_tests++;
            if (obs !== exp_q[i]) begin
                n_fail++;
                $display("FAIL maxrep c%0d got %b exp %b", i, obs, exp_q[i]);
            end
            if (syn && !prev_syn) syn_rise++;
            prev_syn = syn;
            if (done) done_cnt++;
        end
        n_tests++;
        if (syn_rise != 256 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL maxrep_counts syn %0d done %0d exp 256 1", syn_rise, done_cnt);
        end
        tick(1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clear_idle();
        test_basic(0);
        test_basic(2);
        test_retrigger();
        test_bad_len();
        test_abort();
        test_reset_mid();
        test_random(8);
        test_max_rep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
